loglms_to_lab: RTL and testbench
================================

Name: loglms_to_lab

Overview:
- Color-space stage directly downstream of the per-channel log2 converter in the RGB-to-lαβ path.
- Accepts one pixel's three log2 cone responses (logL, logM, logS) and applies the decorrelating transform:
  - l = (L+M+S)/√3
  - α = (L+M−2S)/√6
  - β = (L−M)/√2
- Uses one shared constant multiplier, sequenced by an FSM.
- Valid/ready handshake on both sides; feeds the downstream lαβ statistics/transfer stage.

Parameters:
- IW, 16, input width; unsigned Q3.13 log2 value.
- CW, 16, coefficient width; unsigned Q1.15 constants.
- OW, 20, output width; signed two's-complement Q(OW−13).13.
- C_L, 18919, round(32768/√3).
- C_A, 13378, round(32768/√6).
- C_B, 23170, round(32768/√2).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset.
- i_valid  in  1  input pixel valid.
- o_ready  out  1  block can accept an input pixel.
- i_log_l  in  IW  log2 L, Q3.13.
- i_log_m  in  IW  log2 M, Q3.13.
- i_log_s  in  IW  log2 S, Q3.13.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_l  out  OW  l channel, signed Q.13.
- o_a  out  OW  α channel, signed Q.13.
- o_b  out  OW  β channel, signed Q.13.

Behaviour:
- Reset: i_rst is synchronous, active-high. On reset:
  - state=IDLE; o_valid=0; o_l=o_a=o_b=0; all internal sum and input registers = 0.
  - o_ready=1 in the first cycle after reset.
- o_ready is combinational: 1 iff state==IDLE.
- FSM states: IDLE, SUM, MUL_L, MUL_A, MUL_B, OUT.
  - IDLE: on i_valid&o_ready, register the three inputs and go to SUM. Otherwise stay in IDLE.
  - SUM: register three sums, then go to MUL_L.
    - s0 = L+M+S, unsigned, IW+2 bits.
    - s1 = L+M−2S, signed, IW+3 bits.
    - s2 = L−M, signed, IW+2 bits.
  - MUL_L: o_l ← R(s0·C_L), then go to MUL_A.
  - MUL_A: o_a ← R(s1·C_A), then go to MUL_B.
  - MUL_B: o_b ← R(s2·C_B); o_valid←1; go to OUT.
  - OUT: hold o_valid=1 and all outputs stable until i_ready=1. On that edge: o_valid←0, go to IDLE. Outputs keep their last values.
- Timing:
  - Acceptance at edge k gives o_valid=1 after edge k+4.
  - Minimum issue interval is 6 cycles, including the OUT handshake cycle.
- R(x) = (x + 2^(CW−2)) >>> (CW−1). This is arithmetic, round-half-up toward +∞, computed at full product width with no intermediate truncation.
  - If the result lies outside the OW signed range, saturate to the range limit. The range is not reachable with default parameters.
- Only one multiplier instance exists. Its coefficient and operand are selected by state.
- i_valid while o_ready=0 is ignored. Inputs are not sampled outside an IDLE transfer.
- o_l/o_a/o_b are individually updated during MUL states. Consumers use them only while o_valid=1.
- Reset asserted in any state, including OUT with i_ready=1 in the same cycle: reset wins. The in-flight pixel is dropped and no o_valid is produced for it.
- Inputs are treated as unsigned. Zero input (log2 of 1) is legal.

Test Plan:
1. L=M=S=0x2000 (1.0) -> after 4 cycles: o_valid=1, o_l=14189, o_a=0, o_b=0; with i_ready=1, o_ready returns next cycle.
2. L=0x4000, M=0x2000, S=0 -> o_l=14189, o_a=10034, o_b=5793 (exact-half rounding up).
3. L=0, M=0x2000, S=0x2000 -> o_l=9460, o_a=−3344 (0xFF2F0), o_b=−5792 (0xFE960).
4. L=M=S=0xFFFF -> o_l=113512, no saturation; o_a=0, o_b=0.
5. Back-pressure: hold i_ready=0 for 10 cycles in OUT while toggling i_valid and inputs -> o_valid stays 1, outputs constant, o_ready=0, no new pixel accepted; release i_ready -> exactly one transfer.
6. Assert i_rst during MUL_A, then release -> o_valid=0, outputs 0, o_ready=1 next cycle; a subsequent pixel completes with correct values and 4-cycle latency.

Source files
------------

// File: rtl/loglms_to_lab.sv
// Log-domain LMS to l-alpha-beta decorrelating transform: three sums followed by
// three scaled products, all sharing one constant multiplier sequenced by an FSM.
module loglms_to_lab #(
  parameter int IW  = 16,
  parameter int CW  = 16,
  parameter int OW  = 20,
  parameter int C_L = 18919,
  parameter int C_A = 13378,
  parameter int C_B = 23170
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [IW-1:0] i_log_l,
  input  logic [IW-1:0] i_log_m,
  input  logic [IW-1:0] i_log_s,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [OW-1:0] o_l,
  output logic [OW-1:0] o_a,
  output logic [OW-1:0] o_b
);

  // Handshake: a transfer happens on any rising edge where valid and ready are
  // both high; o_ready is high only in IDLE, and o_valid holds in OUT until i_ready.

  // Operand is signed IW+3 bits, coefficient a non-negative signed CW+1 bits.
  localparam int PW = IW + 3 + CW + 1;
  localparam int RW = PW - (CW - 1);

  localparam logic [CW-1:0] COEF_L = CW'(C_L);
  localparam logic [CW-1:0] COEF_A = CW'(C_A);
  localparam logic [CW-1:0] COEF_B = CW'(C_B);

  localparam logic signed [PW-1:0] HALF = {{(PW-CW+1){1'b0}}, 1'b1, {(CW-2){1'b0}}};
  localparam logic signed [OW-1:0] OUT_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] OUT_MIN = {1'b1, {(OW-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SUM   = 3'd1,
    MUL_L = 3'd2,
    MUL_A = 3'd3,
    MUL_B = 3'd4,
    OUT   = 3'd5
  } state_t;

  state_t state;

  logic [IW-1:0]          in_l;
  logic [IW-1:0]          in_m;
  logic [IW-1:0]          in_s;
  logic [IW+1:0]          s0;
  logic signed [IW+2:0]   s1;
  logic signed [IW+1:0]   s2;

  logic signed [IW+2:0]   mul_op;
  logic signed [CW:0]     mul_coef;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   prod_rnd;
  logic signed [RW-1:0]   rnd;
  logic                   rnd_fits;
  logic signed [OW-1:0]   rnd_sat;

  assign o_ready = (state == IDLE);

  // The single multiplier: operand and coefficient are steered by the current state.
  always_comb begin
    mul_op   = '0;
    mul_coef = '0;
    case (state)
      MUL_L: begin
        mul_op   = {1'b0, s0};
        mul_coef = {1'b0, COEF_L};
      end
      MUL_A: begin
        mul_op   = s1;
        mul_coef = {1'b0, COEF_A};
      end
      MUL_B: begin
        mul_op   = {s2[IW+1], s2};
        mul_coef = {1'b0, COEF_B};
      end
      default: begin
        mul_op   = '0;
        mul_coef = '0;
      end
    endcase
  end

  // Round half up at full product width, then take the arithmetic shift by CW-1.
  always_comb begin
    prod     = PW'(mul_op) * PW'(mul_coef);
    prod_rnd = prod + HALF;
    rnd      = prod_rnd[PW-1:CW-1];
    rnd_fits = (&rnd[RW-1:OW-1]) | ~(|rnd[RW-1:OW-1]);
    if (rnd_fits) begin
      rnd_sat = rnd[OW-1:0];
    end else if (rnd[RW-1]) begin
      rnd_sat = OUT_MIN;
    end else begin
      rnd_sat = OUT_MAX;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      o_l     <= '0;
      o_a     <= '0;
      o_b     <= '0;
      in_l    <= '0;
      in_m    <= '0;
      in_s    <= '0;
      s0      <= '0;
      s1      <= '0;
      s2      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            in_l  <= i_log_l;
            in_m  <= i_log_m;
            in_s  <= i_log_s;
            state <= SUM;
          end
        end
        SUM: begin
          s0    <= {2'b00, in_l} + {2'b00, in_m} + {2'b00, in_s};
          s1    <= $signed({3'b000, in_l}) + $signed({3'b000, in_m})
                   - $signed({2'b00, in_s, 1'b0});
          s2    <= $signed({2'b00, in_l}) - $signed({2'b00, in_m});
          state <= MUL_L;
        end
        MUL_L: begin
          o_l   <= rnd_sat;
          state <= MUL_A;
        end
        MUL_A: begin
          o_a   <= rnd_sat;
          state <= MUL_B;
        end
        MUL_B: begin
          o_b     <= rnd_sat;
          o_valid <= 1'b1;
          state   <= OUT;
        end
        OUT: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_loglms_to_lab.sv
// Directed bench for loglms_to_lab: hand-computed pixel results, latency,
// back-pressure hold and reset abort.
module tb_loglms_to_lab;

  localparam int IW = 16;
  localparam int OW = 20;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic [IW-1:0] log_l;
  logic [IW-1:0] log_m;
  logic [IW-1:0] log_s;
  logic          out_valid;
  logic          down_ready;
  logic [OW-1:0] res_l;
  logic [OW-1:0] res_a;
  logic [OW-1:0] res_b;

  int tests_run = 0;
  int tests_failed = 0;

  loglms_to_lab dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (in_valid),
    .o_ready (out_ready),
    .i_log_l (log_l),
    .i_log_m (log_m),
    .i_log_s (log_s),
    .o_valid (out_valid),
    .i_ready (down_ready),
    .o_l     (res_l),
    .o_a     (res_a),
    .o_b     (res_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, observed, observed, expected, expected);
    end
  endtask

  function automatic logic [31:0] o20(input int v);
    logic [OW-1:0] t;
    t = OW'(v);
    return {12'b0, t};
  endfunction

  // Present one pixel while IDLE, check 4-cycle latency and results, then hand it off.
  task automatic run_pixel(input string tag, input logic [IW-1:0] l, input logic [IW-1:0] m,
                           input logic [IW-1:0] s, input int el, input int ea, input int eb);
    @(negedge clk);
    check({tag, " ready_before"}, {31'b0, out_ready}, 32'd1);
    in_valid = 1'b1;
    log_l = l;
    log_m = m;
    log_s = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    log_l = IW'($urandom_range(0, 65535));
    log_m = IW'($urandom_range(0, 65535));
    log_s = IW'($urandom_range(0, 65535));
    repeat (2) @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check({tag, " valid_k3"}, {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check({tag, " valid_k4"}, {31'b0, out_valid}, 32'd1);
    check({tag, " ready_out"}, {31'b0, out_ready}, 32'd0);
    check({tag, " l"}, {12'b0, res_l}, o20(el));
    check({tag, " a"}, {12'b0, res_a}, o20(ea));
    check({tag, " b"}, {12'b0, res_b}, o20(eb));
    down_ready = 1'b1;
    @(posedge clk);
    #1;
    down_ready = 1'b0;
    @(negedge clk);
    check({tag, " valid_after"}, {31'b0, out_valid}, 32'd0);
    check({tag, " ready_after"}, {31'b0, out_ready}, 32'd1);
    check({tag, " l_kept"}, {12'b0, res_l}, o20(el));
  endtask

  // Accept a pixel and leave the bench just after edge k+n.
  task automatic start_pixel(input logic [IW-1:0] l, input logic [IW-1:0] m,
                             input logic [IW-1:0] s, input int n);
    @(negedge clk);
    in_valid = 1'b1;
    log_l = l;
    log_m = m;
    log_s = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [OW-1:0] held_l;
    logic [OW-1:0] held_a;
    logic [OW-1:0] held_b;

    rst = 1'b1;
    in_valid = 1'b0;
    down_ready = 1'b0;
    log_l = '0;
    log_m = '0;
    log_s = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset ready", {31'b0, out_ready}, 32'd1);
    check("reset valid", {31'b0, out_valid}, 32'd0);
    check("reset l", {12'b0, res_l}, 32'd0);
    check("reset a", {12'b0, res_a}, 32'd0);
    check("reset b", {12'b0, res_b}, 32'd0);

    run_pixel("t1_unity", 16'h2000, 16'h2000, 16'h2000, 14189, 0, 0);
    run_pixel("t2_half",  16'h4000, 16'h2000, 16'h0000, 14189, 10034, 5793);
    run_pixel("t3_neg",   16'h0000, 16'h2000, 16'h2000, 9460, -3344, -5792);
    run_pixel("t4_max",   16'hFFFF, 16'hFFFF, 16'hFFFF, 113512, 0, 0);
    run_pixel("t_zero",   16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    run_pixel("t_mmax",   16'h0000, 16'hFFFF, 16'h0000, 37837, 26756, -46339);

    // Back-pressure: sit in OUT for 10 cycles while inputs churn.
    start_pixel(16'h4000, 16'h2000, 16'h0000, 4);
    @(negedge clk);
    held_l = res_l;
    held_a = res_a;
    held_b = res_b;
    check("bp l_entry", {12'b0, held_l}, o20(14189));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      log_l = IW'($urandom_range(0, 65535));
      log_m = IW'($urandom_range(0, 65535));
      log_s = IW'($urandom_range(0, 65535));
      @(negedge clk);
      check("bp valid", {31'b0, out_valid}, 32'd1);
      check("bp ready", {31'b0, out_ready}, 32'd0);
      check("bp l", {12'b0, res_l}, {12'b0, held_l});
      check("bp a", {12'b0, res_a}, {12'b0, held_a});
      check("bp b", {12'b0, res_b}, {12'b0, held_b});
    end
    in_valid = 1'b0;
    down_ready = 1'b1;
    @(posedge clk);
    #1;
    down_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp post valid", {31'b0, out_valid}, 32'd0);
      check("bp post ready", {31'b0, out_ready}, 32'd1);
    end

    // Reset during MUL_A drops the pixel.
    start_pixel(16'h4000, 16'h2000, 16'h0000, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mula valid", {31'b0, out_valid}, 32'd0);
    check("rst_mula ready", {31'b0, out_ready}, 32'd1);
    check("rst_mula l", {12'b0, res_l}, 32'd0);
    check("rst_mula a", {12'b0, res_a}, 32'd0);
    check("rst_mula b", {12'b0, res_b}, 32'd0);
    repeat (5) begin
      @(negedge clk);
      check("rst_mula no_valid", {31'b0, out_valid}, 32'd0);
    end
    run_pixel("t6_after_rst", 16'h0000, 16'h2000, 16'h2000, 9460, -3344, -5792);

    // Reset in OUT with i_ready high in the same cycle: reset wins.
    start_pixel(16'h2000, 16'h2000, 16'h2000, 4);
    rst = 1'b1;
    down_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    down_ready = 1'b0;
    @(negedge clk);
    check("rst_out valid", {31'b0, out_valid}, 32'd0);
    check("rst_out ready", {31'b0, out_ready}, 32'd1);
    check("rst_out l", {12'b0, res_l}, 32'd0);

    run_pixel("t_final", 16'h2000, 16'h2000, 16'h2000, 14189, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
